// File: rtl/udm_tx_pkg.sv
// Shared types and constants for the UART debug-link transmitter.
package udm_tx_pkg;

  localparam int unsigned DATA_BITS   = 8;
  localparam int unsigned MIN_DIVIDER = 2;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

endpackage

// File: rtl/udm_tx_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two.
module udm_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full blocks a push even when a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/udm_tx.sv
// UART transmitter for the debug link: byte FIFO feeding an 8N1/8N2 serialiser
// with a divider latched at the start of every frame.
module udm_tx
  import udm_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned DIV_WIDTH  = 32,
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DIV_WIDTH-1:0] cfg_divider_i,
  input  logic                 tx_req_i,
  input  logic [7:0]           tx_data_i,
  output logic                 tx_ack_o,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic [CNT_W-1:0]     fifo_cnt_o
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  tx_state_e            state_q;
  logic [DIV_WIDTH-1:0] div_q, bit_cnt_q, div_start;
  logic [IDX_W-1:0]     bit_idx_q;
  logic                 stop_idx_q;
  logic [7:0]           shift_q;
  logic                 tx_q;

  logic       fifo_full, fifo_empty, fifo_pop;
  logic [7:0] fifo_rdata;
  logic       last_stop, frame_end;

  udm_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (tx_req_i && tx_ack_o),
    .wdata_i (tx_data_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt_o)
  );

  assign div_start = (cfg_divider_i < DIV_WIDTH'(MIN_DIVIDER)) ? DIV_WIDTH'(MIN_DIVIDER)
                                                               : cfg_divider_i;
  assign last_stop = (stop_idx_q == 1'(STOP_BITS - 1));
  assign frame_end = (state_q == StStop) && (bit_cnt_q == '0) && last_stop;
  // Popping at the end of a stop interval chains frames with no idle gap.
  assign fifo_pop  = !fifo_empty && ((state_q == StIdle) || frame_end);

  assign tx_ack_o = !fifo_full;
  assign tx_o     = tx_q;
  assign busy_o   = (state_q != StIdle) || !fifo_empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (fifo_pop) begin
            state_q   <= StStart;
            shift_q   <= fifo_rdata;
            div_q     <= div_start;
            bit_cnt_q <= div_start - DIV_WIDTH'(1);
            tx_q      <= 1'b0;
          end
        end
        StStart: begin
          if (bit_cnt_q == '0) begin
            state_q   <= StData;
            bit_idx_q <= '0;
            bit_cnt_q <= div_q - DIV_WIDTH'(1);
            tx_q      <= shift_q[0];
          end else begin
            bit_cnt_q <= bit_cnt_q - DIV_WIDTH'(1);
          end
        end
        StData: begin
          if (bit_cnt_q == '0) begin
            bit_cnt_q <= div_q - DIV_WIDTH'(1);
            if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
              state_q    <= StStop;
              stop_idx_q <= 1'b0;
              tx_q       <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + IDX_W'(1);
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - DIV_WIDTH'(1);
          end
        end
        StStop: begin
          if (bit_cnt_q != '0) begin
            bit_cnt_q <= bit_cnt_q - DIV_WIDTH'(1);
          end else if (!last_stop) begin
            stop_idx_q <= 1'b1;
            bit_cnt_q  <= div_q - DIV_WIDTH'(1);
          end else if (fifo_pop) begin
            state_q   <= StStart;
            shift_q   <= fifo_rdata;
            div_q     <= div_start;
            bit_cnt_q <= div_start - DIV_WIDTH'(1);
            tx_q      <= 1'b0;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_udm_tx.sv
// Self-checking bench for udm_tx: line waveforms compared against frames built
// from byte values and divider settings.
module tb_udm_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] div_a = 32'd4, div_b = 32'd4;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [7:0]  data_a = '0, data_b = '0;
  logic        ack_a, tx_a, busy_a, ack_b, tx_b, busy_b;
  logic [2:0]  cnt_a, cnt_b;

  always #5 clk = ~clk;

  udm_tx #(.FIFO_DEPTH(4), .STOP_BITS(1), .DIV_WIDTH(32)) dut_a (
    .clk_i(clk), .rst_i(rst), .cfg_divider_i(div_a), .tx_req_i(req_a), .tx_data_i(data_a),
    .tx_ack_o(ack_a), .tx_o(tx_a), .busy_o(busy_a), .fifo_cnt_o(cnt_a)
  );

  udm_tx #(.FIFO_DEPTH(4), .STOP_BITS(2), .DIV_WIDTH(32)) dut_b (
    .clk_i(clk), .rst_i(rst), .cfg_divider_i(div_b), .tx_req_i(req_b), .tx_data_i(data_b),
    .tx_ack_o(ack_b), .tx_o(tx_b), .busy_o(busy_b), .fifo_cnt_o(cnt_b)
  );

  int total_n = 0;
  int bad_n   = 0;

  int         div_at[int];
  logic [7:0] push_at[int];
  bit         rst_at[int];
  bit         obs_q[$], busy_q[$], ack_q[$], exp_q[$];
  logic [2:0] cnt_obs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line levels for one frame: start, 8 data bits LSB first, stop bits.
  task automatic add_frame(input logic [7:0] b, input int div, input int stop, inout int span);
    int eff;
    eff = (div < 2) ? 2 : div;
    for (int p = 0; p < 9 + stop; p++) begin
      bit lvl;
      lvl = (p == 0) ? 1'b0 : (p <= 8) ? b[p-1] : 1'b1;
      repeat (eff) exp_q.push_back(lvl);
    end
    span += (9 + stop) * eff;
  endtask

  // obs_q[k] holds the outputs just after edge N+k, where N is the cycle-0 edge.
  task automatic run(input bit sel, input int ncycles);
    obs_q.delete(); busy_q.delete(); ack_q.delete(); cnt_obs.delete();
    for (int c = 0; c <= ncycles; c++) begin
      if (div_at.exists(c)) begin
        if (sel) div_b = div_at[c]; else div_a = div_at[c];
      end
      rst = rst_at.exists(c);
      if (sel) begin
        req_b = push_at.exists(c);
        if (req_b) begin data_b = push_at[c]; ack_q.push_back(ack_b); end
      end else begin
        req_a = push_at.exists(c);
        if (req_a) begin data_a = push_at[c]; ack_q.push_back(ack_a); end
      end
      tick();
      obs_q.push_back(sel ? tx_b : tx_a);
      busy_q.push_back(sel ? busy_b : busy_a);
      cnt_obs.push_back(sel ? cnt_b : cnt_a);
    end
    req_a = 1'b0; req_b = 1'b0; rst = 1'b0;
    div_at.delete(); push_at.delete(); rst_at.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_n += 5;
    if (tx_a !== 1'b1) begin bad_n++; $display("FAIL reset_tx: got %b want 1", tx_a); end
    if (ack_a !== 1'b1) begin bad_n++; $display("FAIL reset_ack: got %b want 1", ack_a); end
    if (busy_a !== 1'b0) begin bad_n++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    if (cnt_a !== 3'd0) begin bad_n++; $display("FAIL reset_cnt: got %0d want 0", cnt_a); end
    if (tx_b !== 1'b1) begin bad_n++; $display("FAIL reset_tx_b: got %b want 1", tx_b); end
  endtask

  task automatic test_single();
    int span = 0, errs = 0, first = -1;
    exp_q.delete(); exp_q.push_back(1'b1);
    add_frame(8'h55, 4, 1, span);
    div_at[0] = 4; push_at[0] = 8'h55;
    run(1'b0, span + 5);
    for (int k = 0; k < int'(obs_q.size()); k++) begin
      bit e;
      e = (k < int'(exp_q.size())) ? exp_q[k] : 1'b1;
      if (obs_q[k] !== e || busy_q[k] !== (k <= span)) begin errs++; if (first < 0) first = k; end
    end
    total_n += 4;
    if (errs !== 0) begin
      bad_n++; $display("FAIL single_wave: %0d bad cycles, first at %0d", errs, first);
    end
    if (obs_q[0] !== 1'b1 || obs_q[1] !== 1'b0) begin
      bad_n++; $display("FAIL single_latency: got %b%b want 10", obs_q[0], obs_q[1]);
    end
    if (busy_q[40] !== 1'b1 || busy_q[41] !== 1'b0) begin
      bad_n++; $display("FAIL single_busy_drop: got %b%b want 10", busy_q[40], busy_q[41]);
    end
    if (cnt_obs[0] !== 3'd1) begin
      bad_n++; $display("FAIL single_cnt: got %0d want 1", cnt_obs[0]);
    end
  endtask

  task automatic test_burst();
    logic [7:0] bytes [6] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h77};
    int span = 0, errs = 0, first = -1, accepted = 0;
    bit exp_ack [6];
    exp_q.delete(); exp_q.push_back(1'b1);
    div_at[0] = 4;
    // One pop at edge N+1; everything else fills the 4-deep FIFO.
    for (int k = 0; k < 6; k++) begin
      push_at[k] = bytes[k];
      exp_ack[k] = (accepted - ((k >= 2) ? 1 : 0)) != 4;
      if (exp_ack[k]) begin accepted++; add_frame(bytes[k], 4, 1, span); end
    end
    run(1'b0, span + 5);
    for (int k = 0; k < 6; k++) begin
      total_n++;
      if (ack_q[k] !== exp_ack[k]) begin
        bad_n++; $display("FAIL burst_ack%0d: got %b want %b", k, ack_q[k], exp_ack[k]);
      end
    end
    for (int k = 0; k < int'(obs_q.size()); k++) begin
      bit e;
      e = (k < int'(exp_q.size())) ? exp_q[k] : 1'b1;
      if (obs_q[k] !== e || busy_q[k] !== (k <= span)) begin errs++; if (first < 0) first = k; end
    end
    total_n += 2;
    if (errs !== 0) begin
      bad_n++; $display("FAIL burst_wave: %0d bad cycles, first at %0d", errs, first);
    end
    if (cnt_obs[4] !== 3'd4) begin
      bad_n++; $display("FAIL burst_full_cnt: got %0d want 4", cnt_obs[4]);
    end
  endtask

  task automatic test_div_change();
    int span = 0, errs = 0, first = -1;
    exp_q.delete(); exp_q.push_back(1'b1);
    add_frame(8'h0F, 4, 1, span);
    add_frame(8'hF0, 8, 1, span);
    div_at[0] = 4; push_at[0] = 8'h0F;
    div_at[11] = 8; push_at[20] = 8'hF0;
    run(1'b0, span + 5);
    for (int k = 0; k < int'(obs_q.size()); k++) begin
      bit e;
      e = (k < int'(exp_q.size())) ? exp_q[k] : 1'b1;
      if (obs_q[k] !== e || busy_q[k] !== (k <= span)) begin errs++; if (first < 0) first = k; end
    end
    total_n++;
    if (errs !== 0) begin
      bad_n++; $display("FAIL divchg_wave: %0d bad cycles, first at %0d", errs, first);
    end
  endtask

  task automatic test_reset_mid();
    int span = 0, errs = 0, first = -1;
    exp_q.delete(); exp_q.push_back(1'b1);
    add_frame(8'hAA, 4, 1, span);
    div_at[0] = 4; push_at[0] = 8'hAA; push_at[2] = 8'h00;
    rst_at[19] = 1'b1;  // edge N+19 lands inside data bit 3
    run(1'b0, 60);
    for (int k = 0; k < int'(obs_q.size()); k++) begin
      bit e;
      e = (k < 19) ? exp_q[k] : 1'b1;
      if (obs_q[k] !== e || busy_q[k] !== (k < 19)) begin errs++; if (first < 0) first = k; end
    end
    total_n += 2;
    if (errs !== 0) begin
      bad_n++; $display("FAIL rstmid_wave: %0d bad cycles, first at %0d", errs, first);
    end
    if (cnt_obs[19] !== 3'd0) begin
      bad_n++; $display("FAIL rstmid_cnt: got %0d want 0", cnt_obs[19]);
    end
  endtask

  task automatic test_clamp();
    int span = 0, errs = 0, first = -1;
    exp_q.delete(); exp_q.push_back(1'b1);
    add_frame(8'h01, 0, 1, span);
    div_at[0] = 0; push_at[0] = 8'h01;
    run(1'b0, span + 5);
    for (int k = 0; k < int'(obs_q.size()); k++) begin
      bit e;
      e = (k < int'(exp_q.size())) ? exp_q[k] : 1'b1;
      if (obs_q[k] !== e || busy_q[k] !== (k <= span)) begin errs++; if (first < 0) first = k; end
    end
    total_n++;
    if (errs !== 0 || span != 20) begin
      bad_n++; $display("FAIL clamp_wave: %0d bad cycles, first at %0d", errs, first);
    end
  endtask

  task automatic test_stop2();
    int span = 0, errs = 0, first = -1;
    exp_q.delete(); exp_q.push_back(1'b1);
    add_frame(8'h80, 4, 2, span);
    add_frame(8'h80, 4, 2, span);
    div_at[0] = 4; push_at[0] = 8'h80; push_at[1] = 8'h80;
    run(1'b1, span + 5);
    for (int k = 0; k < int'(obs_q.size()); k++) begin
      bit e;
      e = (k < int'(exp_q.size())) ? exp_q[k] : 1'b1;
      if (obs_q[k] !== e || busy_q[k] !== (k <= span)) begin errs++; if (first < 0) first = k; end
    end
    total_n++;
    if (errs !== 0) begin
      bad_n++; $display("FAIL stop2_wave: %0d bad cycles, first at %0d", errs, first);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      bit sel;
      int div, n, span = 0, errs = 0, first = -1, accepted = 0, ack_errs = 0;
      bit exp_ack [$];
      sel = 1'($urandom_range(0, 1));
      div = $urandom_range(0, 6);
      n   = $urandom_range(1, 6);
      exp_q.delete(); exp_q.push_back(1'b1);
      div_at[0] = div;
      for (int k = 0; k < n; k++) begin
        logic [7:0] b;
        b = 8'($urandom);
        push_at[k] = b;
        exp_ack.push_back((accepted - ((k >= 2) ? 1 : 0)) != 4);
        if (exp_ack[k]) begin accepted++; add_frame(b, div, sel ? 2 : 1, span); end
      end
      run(sel, span + 5);
      for (int k = 0; k < n; k++) if (ack_q[k] !== exp_ack[k]) ack_errs++;
      for (int k = 0; k < int'(obs_q.size()); k++) begin
        bit e;
        e = (k < int'(exp_q.size())) ? exp_q[k] : 1'b1;
        if (obs_q[k] !== e || busy_q[k] !== (k <= span)) begin errs++; if (first < 0) first = k; end
      end
      total_n += 2;
      if (ack_errs !== 0) begin
        bad_n++; $display("FAIL rand%0d_ack: %0d wrong acks, want 0", it, ack_errs);
      end
      if (errs !== 0) begin
        bad_n++;
        $display("FAIL rand%0d_wave: div=%0d n=%0d sel=%0d, %0d bad cycles, first at %0d",
                 it, div, n, sel, errs, first);
      end
    end
  endtask

  initial begin
    repeat (2) tick();
    test_reset();
    test_single();
    test_burst();
    test_div_change();
    test_reset_mid();
    test_clamp();
    test_stop2();
    test_random();
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
